csr_commit_unit: RTL
====================

Name: csr_commit_unit

Overview:
- Writeback-stage controller that initiates every access to the CSR file.
- Latches one retiring instruction from the MEM stage and resolves final exception status: upstream fault, privilege, syscall/break, illegal op.
- Drives the CSR read/write port, the exception and ertn commit signals, and the regfile write.
- Blocks younger in-flight instructions for a fixed drain window after any redirect.

Parameters:
- FLUSH_CYCLES, 3, cycles that inbound instructions are discarded after wb_ex or ertn_flush (younger stages in flight).
- CSR_NUM_WIDTH, 14, CSR number width; must match the CSR file.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_valid  in  1  MEM stage holds an instruction
- ms_ready  out  1  unit accepts this cycle
- ms_pc  in  32  instruction PC
- ms_op  in  3  0 none, 1 csrrd, 2 csrwr, 3 csrxchg, 4 ertn, 5 syscall, 6 break, 7 illegal
- ms_csr_num  in  CSR_NUM_WIDTH  target CSR
- ms_rd_val  in  32  rd source value (csrwr/csrxchg write data)
- ms_rj_val  in  32  rj value (csrxchg write mask)
- ms_result  in  32  ALU/load result for non-CSR ops
- ms_dest  in  5  destination register
- ms_ex, ms_ecode[6], ms_esubcode[9], ms_vaddr[32]  in  upstream exception info
- csr_plv  in  2  current privilege level
- csr_rvalue  in  32  CSR read data, combinational
- csr_re, csr_we  out  1  CSR read/write enables
- csr_num  out  CSR_NUM_WIDTH
- csr_wmask, csr_wvalue  out  32
- wb_ex, ertn_flush  out  1  commit pulses
- wb_pc, wb_vaddr  out  32
- wb_ecode  out  6
- wb_esubcode  out  9
- rf_we  out  1
- rf_waddr  out  5
- rf_wdata  out  32
- flush  out  1  redirect younger stages (= wb_ex | ertn_flush)

Behaviour:
- Reset: ws_valid=0, state RUN, drain counter 0. All outputs are 0 except ms_ready=1.
- States:
  - RUN: ms_ready=1. On ms_valid the instruction is latched into ws_* at the clock edge. WB is single-cycle; ws_valid is reloaded every cycle (0 when nothing is accepted).
  - DRAIN: ms_ready=1. Accepted instructions are discarded (ws_valid stays 0). The counter decrements each cycle. At 1, transition to RUN.
- Exception resolution for a valid ws instruction, first match wins:
  - ws_ex: upstream ecode, esubcode, vaddr.
  - op in {1,2,3,4} and plv!=0: IPE 0x0E, esub 0.
  - op 5: SYS 0x0B.
  - op 6: BRK 0x0C.
  - op 7: INE 0x0D.
- wb_ex=ws_valid&ex_final, combinational in the WB cycle. wb_pc=ws_pc; wb_vaddr=ws_vaddr.
- On wb_ex:
  - No CSR write, no rf write, csr_re=0.
  - ertn_flush=0.
  - Next state DRAIN with counter=FLUSH_CYCLES.
  - An instruction presented in the same cycle is discarded.
- ertn, no exception: ertn_flush=1 for one cycle, no rf write, then DRAIN identical to the wb_ex case.
- CSR ops, no exception:
  - csr_re=1 for ops 1–3.
  - rf_wdata=csr_rvalue (old value), rf_we=1 when ms_dest!=0.
  - csrwr: csr_we=1, wmask=0xFFFFFFFF, wvalue=rd_val.
  - csrxchg: csr_we=1, wmask=rj_val, wvalue=rd_val.
  - csrrd: csr_we=0.
  - The CSR file commits the write at the following edge. Back-to-back CSR ops to the same CSR therefore see the updated value with no bubble.
- Non-CSR op 0: rf_we=(dest!=0), rf_wdata=ms_result.
- Idle cycles: csr_we, csr_re, rf_we, wb_ex, ertn_flush and flush are all 0.
- FLUSH_CYCLES=0: no DRAIN; return directly to RUN.
- Reset during DRAIN aborts the drain.

Optional Feature:
- Macro CSR_COMMIT_PLV_CHECK_EN.
  - Defined: the IPE check above is active.
  - Undefined: the privilege rule is removed, csr_plv is ignored, and CSR ops/ertn execute at any PLV.

Decomposition:
- The shared constants header holds:
  - op codes
  - ECODE_SYS/BRK/INE/IPE values
  - CSR_NUM_WIDTH
- One natural sub-module, csr_commit_excp_arb: combinational priority resolver producing ex_final, ecode, esubcode, vaddr.

Test Plan:
- csrwr, PLV0, num=SAVE0, rd_val=0xDEADBEEF, dest=4 -> csr_we=1, wmask=FFFFFFFF, wvalue=DEADBEEF, rf_wdata=old SAVE0, rf_waddr=4.
- csrxchg, rj_val=0x0000FF00, rd_val=0x12345678 -> wmask=0000FF00, wvalue=12345678, rf_wdata=old value.
- syscall at pc=0x1C000100, next instr valid the same cycle -> wb_ex=1, wb_ecode=0x0B, flush=1. The following 3 accepted instructions produce no rf_we; the 4th commits.
- csrrd at PLV3 with macro defined -> wb_ex=1, ecode=0x0E, csr_re=0. Macro undefined -> csr_re=1, rf_we=1, no exception.
- ms_ex=1 with ecode ALE and op=break -> wb_ecode=ALE, wb_vaddr=ms_vaddr (upstream wins).
- ertn at PLV0 -> ertn_flush=1 for one cycle, rf_we=0. Reset asserted during DRAIN -> next cycle RUN, ws_valid=0.

Source files
------------

// File: rtl/csr_commit_unit_pkg.sv
// Shared definitions for the CSR commit (writeback) stage: op codes,
// exception codes, CSR number width and the latched WB-stage record.
package csr_commit_unit_pkg;

    localparam int CSR_NUM_WIDTH = 14;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_CSRRD   = 3'd1,
        OP_CSRWR   = 3'd2,
        OP_CSRXCHG = 3'd3,
        OP_ERTN    = 3'd4,
        OP_SYSCALL = 3'd5,
        OP_BREAK   = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // One retiring instruction as held in the WB stage.
    typedef struct packed {
        logic [31:0]              pc;
        op_e                      op;
        logic [CSR_NUM_WIDTH-1:0] csr_num;
        logic [31:0]              rd_val;
        logic [31:0]              rj_val;
        logic [31:0]              result;
        logic [4:0]               dest;
        logic                     ex;
        logic [5:0]               ecode;
        logic [8:0]               esubcode;
        logic [31:0]              vaddr;
    } ws_t;

    // True for the ops that read the CSR file and return its old value.
    function automatic logic is_csr_op(input op_e op);
        return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG);
    endfunction

endpackage

// File: rtl/csr_commit_unit_if.sv
// Bundle of every MEM->WB, CSR-port, exception and regfile signal of the
// commit unit. master = surrounding pipeline/CSR file, slave = commit unit.
interface csr_commit_unit_if;
    import csr_commit_unit_pkg::*;

    // MEM stage handoff
    logic                     ms_valid;
    logic                     ms_ready;
    logic [31:0]              ms_pc;
    logic [2:0]               ms_op;
    logic [CSR_NUM_WIDTH-1:0] ms_csr_num;
    logic [31:0]              ms_rd_val;
    logic [31:0]              ms_rj_val;
    logic [31:0]              ms_result;
    logic [4:0]               ms_dest;
    logic                     ms_ex;
    logic [5:0]               ms_ecode;
    logic [8:0]               ms_esubcode;
    logic [31:0]              ms_vaddr;

    // CSR file port
    logic [1:0]               csr_plv;
    logic [31:0]              csr_rvalue;
    logic                     csr_re;
    logic                     csr_we;
    logic [CSR_NUM_WIDTH-1:0] csr_num;
    logic [31:0]              csr_wmask;
    logic [31:0]              csr_wvalue;

    // Commit / redirect
    logic                     wb_ex;
    logic                     ertn_flush;
    logic [31:0]              wb_pc;
    logic [31:0]              wb_vaddr;
    logic [5:0]               wb_ecode;
    logic [8:0]               wb_esubcode;
    logic                     flush;

    // Register file write
    logic                     rf_we;
    logic [4:0]               rf_waddr;
    logic [31:0]              rf_wdata;

    modport master (
        output ms_valid, ms_pc, ms_op, ms_csr_num, ms_rd_val, ms_rj_val,
               ms_result, ms_dest, ms_ex, ms_ecode, ms_esubcode, ms_vaddr,
               csr_plv, csr_rvalue,
        input  ms_ready, csr_re, csr_we, csr_num, csr_wmask, csr_wvalue,
               wb_ex, ertn_flush, wb_pc, wb_vaddr, wb_ecode, wb_esubcode,
               flush, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ms_valid, ms_pc, ms_op, ms_csr_num, ms_rd_val, ms_rj_val,
               ms_result, ms_dest, ms_ex, ms_ecode, ms_esubcode, ms_vaddr,
               csr_plv, csr_rvalue,
        output ms_ready, csr_re, csr_we, csr_num, csr_wmask, csr_wvalue,
               wb_ex, ertn_flush, wb_pc, wb_vaddr, wb_ecode, wb_esubcode,
               flush, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/csr_commit_excp_arb.sv
// Combinational exception priority resolver for the WB instruction.
// Order: upstream fault, privilege (CSR ops/ertn above PLV0), syscall,
// break, illegal op. The privilege rule exists only when
// CSR_COMMIT_PLV_CHECK_EN is defined.
module csr_commit_excp_arb
    import csr_commit_unit_pkg::*;
(
    input  logic        ex_i,
    input  logic [5:0]  ecode_i,
    input  logic [8:0]  esubcode_i,
    input  logic [31:0] vaddr_i,
    input  op_e         op_i,
    input  logic [1:0]  plv_i,
    output logic        ex_final_o,
    output logic [5:0]  ecode_o,
    output logic [8:0]  esubcode_o,
    output logic [31:0] vaddr_o
);

    logic priv_fault;

`ifdef CSR_COMMIT_PLV_CHECK_EN
    assign priv_fault = (is_csr_op(op_i) || (op_i == OP_ERTN)) && (plv_i != 2'd0);
`else
    // Privilege is not enforced in this build; the PLV input is a no-op.
    logic unused_plv;
    assign unused_plv = ^plv_i;
    assign priv_fault = 1'b0;
`endif

    // The faulting address always travels with the instruction.
    assign vaddr_o = vaddr_i;

    // First matching cause wins.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
        ex_final_o = 1'b0;
        ecode_o    = 6'h00;
        esubcode_o = 9'h000;
        if (ex_i) begin
            ex_final_o = 1'b1;
            ecode_o    = ecode_i;
            esubcode_o = esubcode_i;
        end else if (priv_fault) begin
            ex_final_o = 1'b1;
            ecode_o    = ECODE_IPE;
        end else if (op_i == OP_SYSCALL) begin
            ex_final_o = 1'b1;
            ecode_o    = ECODE_SYS;
        end else if (op_i == OP_BREAK) begin
            ex_final_o = 1'b1;
            ecode_o    = ECODE_BRK;
        end else if (op_i == OP_ILLEGAL) begin
            ex_final_o = 1'b1;
            ecode_o    = ECODE_INE;
        end
    end

endmodule

// File: rtl/csr_commit_unit.sv
// Writeback-stage CSR commit unit. Latches one retiring instruction per
// cycle, resolves its final exception status, drives the CSR port, the
// exception/ertn commit pulses and the regfile write, and discards younger
// instructions for FLUSH_CYCLES cycles after every redirect.
// Optional feature: define CSR_COMMIT_PLV_CHECK_EN to enable the PLV check.
module csr_commit_unit
    import csr_commit_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 3
) (
    input logic               clk,
    input logic               reset,
    csr_commit_unit_if.slave  bus
);

    localparam int                CNT_W    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ws_valid_q, ws_valid_d;
    ws_t              ws_q, ws_d;

    logic             ex_final;
    logic [5:0]       ex_ecode;
    logic [8:0]       ex_esubcode;
    logic [31:0]      ex_vaddr;

    logic             commit;
    logic             wb_ex;
    logic             ertn;
    logic             is_csr;
    logic             csr_wr;
    logic             flush;

    csr_commit_excp_arb u_excp_arb (
        .ex_i       (ws_q.ex),
        .ecode_i    (ws_q.ecode),
        .esubcode_i (ws_q.esubcode),
        .vaddr_i    (ws_q.vaddr),
        .op_i       (ws_q.op),
        .plv_i      (bus.csr_plv),
        .ex_final_o (ex_final),
        .ecode_o    (ex_ecode),
        .esubcode_o (ex_esubcode),
        .vaddr_o    (ex_vaddr)
    );

    // State, drain counter and WB-stage register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ws_valid_q <= 1'b0;
            // NOTE: the payload is reset too so every WB output reads zero straight out of reset.
            ws_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ws_valid_q <= ws_valid_d;
            ws_q       <= ws_d;
        end
    end

    // Next state: any redirect starts a drain window; the window ends when the counter reaches 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush && (FLUSH_CYCLES != 0)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: always ready; keep the offered instruction only in RUN with no redirect this cycle.
    always_comb begin
        bus.ms_ready = 1'b1;
        ws_valid_d   = 1'b0;
        ws_d         = ws_q;
        if ((state_q == ST_RUN) && bus.ms_valid && !flush) begin
            ws_valid_d    = 1'b1;
            ws_d.pc       = bus.ms_pc;
            ws_d.op       = op_e'(bus.ms_op);
            ws_d.csr_num  = bus.ms_csr_num;
            ws_d.rd_val   = bus.ms_rd_val;
            ws_d.rj_val   = bus.ms_rj_val;
            ws_d.result   = bus.ms_result;
            ws_d.dest     = bus.ms_dest;
            ws_d.ex       = bus.ms_ex;
            ws_d.ecode    = bus.ms_ecode;
            ws_d.esubcode = bus.ms_esubcode;
            ws_d.vaddr    = bus.ms_vaddr;
        end
    end

    // WB-cycle commit decode.
    assign commit = ws_valid_q & ~ex_final;
    assign wb_ex  = ws_valid_q & ex_final;
    assign ertn   = commit & (ws_q.op == OP_ERTN);
    assign is_csr = is_csr_op(ws_q.op);
    assign csr_wr = commit & ((ws_q.op == OP_CSRWR) || (ws_q.op == OP_CSRXCHG));
    assign flush  = wb_ex | ertn;

    // CSR port: the old value is read in the WB cycle, the write lands at the next edge.
    assign bus.csr_re     = commit & is_csr;
    assign bus.csr_we     = csr_wr;
    assign bus.csr_num    = ws_q.csr_num;
    assign bus.csr_wmask  = !csr_wr ? 32'h0 :
                            (ws_q.op == OP_CSRXCHG) ? ws_q.rj_val : 32'hFFFF_FFFF;
    assign bus.csr_wvalue = csr_wr ? ws_q.rd_val : 32'h0;

    // Exception / ertn commit.
    assign bus.wb_ex       = wb_ex;
    assign bus.ertn_flush  = ertn;
    assign bus.flush       = flush;
    assign bus.wb_pc       = ws_q.pc;
    assign bus.wb_vaddr    = ex_vaddr;
    assign bus.wb_ecode    = wb_ex ? ex_ecode : 6'h00;
    assign bus.wb_esubcode = wb_ex ? ex_esubcode : 9'h000;

    // Regfile write: CSR ops return the old CSR value, plain ops their result; r0 is never written.
    assign bus.rf_we    = commit & ((ws_q.op == OP_NONE) | is_csr) & (ws_q.dest != 5'd0);
    assign bus.rf_waddr = ws_q.dest;
    assign bus.rf_wdata = is_csr ? bus.csr_rvalue : ws_q.result;

endmodule
